// File: rtl/rb_pkg.sv
// Shared definitions for the register-bank write-port arbiter.
package rb_pkg;

    localparam int unsigned RB_AW         = 4;
    localparam int unsigned RB_DW         = 32;
    localparam int unsigned RB_DEPTH      = 4;
    localparam int unsigned RB_STARVE_MAX = 4;

    // Arbiter FSM: NORMAL arbitrates with WB priority, FORCE drains one late result.
    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } rb_state_e;

endpackage

// File: rtl/rb_lr_fifo.sv
// Late-result FIFO: synchronous, no bypass, with per-entry visibility for hazard masking.
module rb_lr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            push_wc,
    input  logic [DW-1:0]            push_data,
    output logic                     full,
    output logic                     empty,
    output logic [AW-1:0]            head_wc,
    output logic [DW-1:0]            head_data,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [DEPTH-1:0][AW-1:0] entry_wc
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;

    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CNTW-1:0]          count;
    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0][AW-1:0] wc_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic                     push_ok;
    logic                     pop_ok;

    assign full        = (count == CNTW'(DEPTH));
    assign empty       = (count == '0);
    assign push_ok     = push & ~full;
    assign pop_ok      = pop & ~empty;
    assign head_wc     = wc_q[rd_ptr];
    assign head_data   = data_q[rd_ptr];
    assign entry_valid = valid_q;
    assign entry_wc    = wc_q;

    // Pointers, occupancy and entry-valid flags; cleared on reset so queued results are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr          <= wr_ptr + PW'(1);
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr          <= rd_ptr + PW'(1);
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are only meaningful where valid_q is set.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            wc_q[wr_ptr]   <= push_wc;
            data_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rb_wport_arbiter.sv
// Register-bank write-port arbiter: WB has priority, late results are buffered and
// drained when WB is idle or when WB has won too many cycles in a row.
module rb_wport_arbiter
    import rb_pkg::*;
#(
    parameter int unsigned DEPTH      = RB_DEPTH,
    parameter int unsigned STARVE_MAX = RB_STARVE_MAX,
    parameter int unsigned AW         = RB_AW,
    parameter int unsigned DW         = RB_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         in_wb_WC,
    input  logic [DW-1:0]         in_wb_data,
    input  logic                  in_wb_W_RB,
    input  logic                  in_lr_valid,
    input  logic [AW-1:0]         in_lr_WC,
    input  logic [DW-1:0]         in_lr_data,
    output logic                  out_lr_ready,
    output logic                  out_stall,
    output logic [(1<<AW)-1:0]    out_pend_mask,
    output logic [AW-1:0]         out_WC,
    output logic [DW-1:0]         out_WPC,
    output logic                  out_W_RB
);

    localparam int unsigned CW = $clog2(STARVE_MAX) + 1;

    rb_state_e                state_q;
    rb_state_e                state_d;
    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    logic                     grant_wb;
    logic                     grant_fifo;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [AW-1:0]            head_wc;
    logic [DW-1:0]            head_data;
    logic [DEPTH-1:0]         entry_valid;
    logic [DEPTH-1:0][AW-1:0] entry_wc;

    rb_lr_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (in_lr_valid),
        .pop         (grant_fifo),
        .push_wc     (in_lr_WC),
        .push_data   (in_lr_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_wc     (head_wc),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_wc    (entry_wc)
    );

    assign out_lr_ready = ~fifo_full;
    assign out_stall    = (state_q == FORCE);

    // State and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Arbitration: WB wins in NORMAL; after STARVE_MAX consecutive wins over a waiting
    // late result, FORCE freezes the pipeline for one cycle and drains the FIFO head.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_wb   = 1'b0;
        grant_fifo = 1'b0;
        case (state_q)
            NORMAL: begin
                if (in_wb_W_RB) begin
                    grant_wb = 1'b1;
                    if (fifo_empty) begin
                        cnt_d = '0;
                    end else if (cnt_q == CW'(STARVE_MAX - 1)) begin
                        cnt_d   = '0;
                        state_d = FORCE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (!fifo_empty) begin
                    grant_fifo = 1'b1;
                    cnt_d      = '0;
                end
            end
            FORCE: begin
                grant_fifo = ~fifo_empty;
                cnt_d      = '0;
                state_d    = NORMAL;
            end
            default: begin
                state_d = NORMAL;
                cnt_d   = '0;
            end
        endcase
    end

    // Bank write port: the winner lands one cycle after the grant; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_W_RB <= 1'b0;
            out_WC   <= '0;
            out_WPC  <= '0;
        end else begin
            out_W_RB <= grant_wb | grant_fifo;
            if (grant_wb) begin
                out_WC  <= in_wb_WC;
                out_WPC <= in_wb_data;
            end else if (grant_fifo) begin
                out_WC  <= head_wc;
                out_WPC <= head_data;
            end
        end
    end

    // Pending-write mask: one bit per register targeted by any buffered late result.
    always_comb begin
        out_pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                out_pend_mask[entry_wc[i]] = 1'b1;
            end
        end
    end

endmodule
